step_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the step accumulator and drives its ctrl and step inputs. It accepts burst commands over a valid/ready handshake and buffers them in a small FIFO. Each command carries a direction, a 4-bit step magnitude and a repeat count. The block replays each command as a cycle-by-cycle stream of ctrl/step values. A hold input freezes the stream without losing position.

---
 rtl/step_sequencer.sv | 150 +++++++++++++++
 tb/tb_step_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Command sequencer feeding the step accumulator. Buffers {dir, step, count}
// burst commands in a small FIFO and replays each as a cycle-by-cycle ctrl/step
// stream. hold freezes the stream in place; the zero-count command is discarded.
module step_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [3:0]       cmd_step,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             hold,
  output logic             ctrl,
  output logic [3:0]       step,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = CNT_W + 5;

  localparam logic [AW-1:0]    PtrOne  = 1;
  localparam logic [AW:0]      OccOne  = 1;
  localparam logic [AW:0]      OccFull = DEPTH[AW:0];
  localparam logic [CNT_W-1:0] RemOne  = 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic             dir_q;
  logic [3:0]       mag_q;
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      occ_q;
  logic [AW:0]      occ_d;
  logic [EW-1:0]    mem_q [DEPTH];

  logic             push;
  logic             pop;
  logic             fifo_nz;
  logic             occ_nz_d;
  logic [EW-1:0]    head;
  logic             head_dir;
  logic [3:0]       head_mag;
  logic [CNT_W-1:0] head_cnt;

  assign head     = mem_q[rptr_q];
  assign head_dir = head[EW-1];
  assign head_mag = head[EW-2 -: 4];
  assign head_cnt = head[CNT_W-1:0];
  assign fifo_nz  = (occ_q != '0);
  assign push     = cmd_valid & cmd_ready;
  // Pop condition mirrors the FSM: IDLE takes any head, RUN only on the last repeat.
  assign pop      = fifo_nz & ((state_q == StIdle) | (!hold & (rem_q == RemOne)));

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OccOne;
    end else if (!push && pop) begin
      occ_d = occ_q - OccOne;
    end
  end

  assign occ_nz_d = (occ_d != '0);

  // Command storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wptr_q] <= {cmd_dir, cmd_step, cmd_count};
    end
  end

  // FIFO pointers, replay FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      mag_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      cmd_ready <= 1'b0;
      ctrl      <= 1'b0;
      step      <= '0;
      busy      <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrOne;
      if (pop)  rptr_q <= rptr_q + PtrOne;
      occ_q     <= occ_d;
      cmd_ready <= (occ_d != OccFull);

      unique case (state_q)
        StIdle: begin
          if (fifo_nz && head_cnt != '0) begin
            state_q <= StRun;
            dir_q   <= head_dir;
            mag_q   <= head_mag;
            rem_q   <= head_cnt;
            ctrl    <= head_dir;
            step    <= head_mag;
            busy    <= 1'b1;
          end else begin
            if (fifo_nz) done_cnt <= done_cnt + 8'd1;
            ctrl <= 1'b0;
            step <= '0;
            busy <= occ_nz_d;
          end
        end
        StRun: begin
          if (hold) begin
            ctrl <= dir_q;
            step <= '0;
            busy <= 1'b1;
          end else if (rem_q != RemOne) begin
            rem_q <= rem_q - RemOne;
            ctrl  <= dir_q;
            step  <= mag_q;
            busy  <= 1'b1;
          end else if (fifo_nz && head_cnt != '0) begin
            // Chain straight into the next command with no bubble.
            done_cnt <= done_cnt + 8'd1;
            dir_q    <= head_dir;
            mag_q    <= head_mag;
            rem_q    <= head_cnt;
            ctrl     <= head_dir;
            step     <= head_mag;
            busy     <= 1'b1;
          end else begin
            // Completed; a popped zero-count head completes too.
            done_cnt <= done_cnt + (fifo_nz ? 8'd2 : 8'd1);
            state_q  <= StIdle;
            ctrl     <= 1'b0;
            step     <= '0;
            busy     <= occ_nz_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: outputs are sampled on the falling edge,
// inputs are driven on the falling edge and take effect at the next rising edge.
module tb_step_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [3:0]       cmd_step;
  logic [CNT_W-1:0] cmd_count;
  logic             hold;
  logic             ctrl;
  logic [3:0]       step;
  logic             busy;
  logic [7:0]       done_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_done;
  logic [4:0] b2b [5];

  always #5 clk = ~clk;

  step_sequencer #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_step (cmd_step),
    .cmd_count(cmd_count),
    .hold     (hold),
    .ctrl     (ctrl),
    .step     (step),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic c, input logic [3:0] s);
    check(tag, 32'({ctrl, step}), 32'({c, s}));
  endtask

  // Presents one command for a single rising edge; returns on the next falling edge.
  task automatic push_cmd(input logic d, input logic [3:0] s, input logic [CNT_W-1:0] c);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_step  = s;
    cmd_count = c;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] s_exp;
    logic       c_exp;

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_step  = '0;
    cmd_count = '0;
    hold      = 1'b0;
    exp_done  = 8'd0;
    b2b[0] = 5'h02; b2b[1] = 5'h02; b2b[2] = 5'h15; b2b[3] = 5'h15; b2b[4] = 5'h15;

    // Reset and release
    repeat (3) @(negedge clk);
    check_out("rst_out", 1'b0, 4'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(cmd_ready), 32'd1);
    check("rel_busy", 32'(busy), 32'd0);
    check_out("rel_out", 1'b0, 4'd0);

    // Single command {1,3,4}
    push_cmd(1'b1, 4'd3, 4'd4);
    check_out("single_lat", 1'b0, 4'd0);
    check("single_busy_q", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out("single_run", 1'b1, 4'd3);
    end
    @(negedge clk);
    exp_done = exp_done + 8'd1;
    check_out("single_end", 1'b0, 4'd0);
    check("single_done", 32'(done_cnt), 32'(exp_done));
    check("single_busy", 32'(busy), 32'd0);

    // Back-to-back {0,2,2} then {1,5,3}, no gap
    push_cmd(1'b0, 4'd2, 4'd2);
    push_cmd(1'b1, 4'd5, 4'd3);
    for (int i = 0; i < 5; i++) begin
      check_out("b2b_stream", b2b[i][4], b2b[i][3:0]);
      @(negedge clk);
    end
    exp_done = exp_done + 8'd2;
    check_out("b2b_end", 1'b0, 4'd0);
    check("b2b_done", 32'(done_cnt), 32'(exp_done));

    // Full FIFO: A runs while B..E fill the FIFO
    push_cmd(1'b0, 4'd1, 4'd15);
    push_cmd(1'b0, 4'd2, 4'd15);
    push_cmd(1'b0, 4'd3, 4'd15);
    push_cmd(1'b0, 4'd4, 4'd15);
    push_cmd(1'b0, 4'd5, 4'd15);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check_out("full_a", 1'b0, 4'd1);
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("full_reraise_cycles", 32'(n), 32'd12);
    for (int i = 0; i < 62; i++) begin
      if (i < 60) begin
        c_exp = 1'b0;
        s_exp = 4'(2 + i / 15);
      end else if (i == 60) begin
        c_exp = 1'b1;
        s_exp = 4'd6;
      end else begin
        c_exp = 1'b0;
        s_exp = 4'd0;
      end
      check_out("full_stream", c_exp, s_exp);
      if (i == 0) push_cmd(1'b1, 4'd6, 4'd1);
      else @(negedge clk);
    end
    exp_done = exp_done + 8'd6;
    check("full_done", 32'(done_cnt), 32'(exp_done));
    check("full_busy", 32'(busy), 32'd0);

    // Hold for 3 cycles in the middle of {1,7,5}
    push_cmd(1'b1, 4'd7, 4'd5);
    check_out("hold_lat", 1'b0, 4'd0);
    @(negedge clk);
    check_out("hold_pre", 1'b1, 4'd7);
    @(negedge clk);
    check_out("hold_pre", 1'b1, 4'd7);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("hold_freeze", 1'b1, 4'd0);
      check("hold_busy", 32'(busy), 32'd1);
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_out("hold_post", 1'b1, 4'd7);
    end
    @(negedge clk);
    exp_done = exp_done + 8'd1;
    check_out("hold_end", 1'b0, 4'd0);
    check("hold_done", 32'(done_cnt), 32'(exp_done));

    // Zero-count command {0,9,0}
    push_cmd(1'b0, 4'd9, 4'd0);
    check_out("zero_lat", 1'b0, 4'd0);
    check("zero_busy_q", 32'(busy), 32'd1);
    @(negedge clk);
    exp_done = exp_done + 8'd1;
    check_out("zero_out", 1'b0, 4'd0);
    check("zero_done", 32'(done_cnt), 32'(exp_done));
    check("zero_busy", 32'(busy), 32'd0);

    // Reset during the 2nd repeat of {1,4,6} with two commands queued
    push_cmd(1'b1, 4'd4, 4'd6);
    push_cmd(1'b0, 4'd8, 4'd3);
    push_cmd(1'b1, 4'd9, 4'd2);
    check_out("mid_second", 1'b1, 4'd4);
    rst = 1'b0;
    @(negedge clk);
    check_out("mid_rst_out", 1'b0, 4'd0);
    check("mid_rst_done", 32'(done_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_out("mid_quiet", 1'b0, 4'd0);
      check("mid_quiet_busy", 32'(busy), 32'd0);
    end
    check("mid_ready", 32'(cmd_ready), 32'd1);
    check("mid_done", 32'(done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
